// File: rtl/matrix_pkg.sv
// Shared constants, FSM state encoding and length helpers for the matrix-multiply datapath.
package matrix_pkg;

    localparam int unsigned DEF_ELEM_W = 8;
    localparam int unsigned DEF_BUS_W  = 128;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StHold  = 3'd3,
        StErr   = 3'd4
    } state_e;

    // Bits occupied by a packed rows x cols matrix.
    function automatic int unsigned matrix_len(input int unsigned rows, input int unsigned cols,
                                               input int unsigned elem_w);
        return rows * cols * elem_w;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Element stream in, packed matrices out, plus the mat_valid/mat_ack handshake.
interface matrix_loader_if #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned BUS_W  = 128
);
    logic              start;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [BUS_W-1:0]  a_out;
    logic [BUS_W-1:0]  b_out;
    logic              mat_valid;
    logic              mat_ack;
    logic              err;

    modport master (
        output start, in_data, in_valid, in_last, mat_ack,
        input  in_ready, a_out, b_out, mat_valid, err
    );

    modport slave (
        input  start, in_data, in_valid, in_last, mat_ack,
        output in_ready, a_out, b_out, mat_valid, err
    );
endinterface

// File: rtl/elem_packer.sv
// Packs a row-major element stream into a flat bus, first element at the MSB of the used field.
module elem_packer #(
    parameter int unsigned NumElem = 6,
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned BUS_W   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [ELEM_W-1:0] data_i,
    output logic              full_o,
    output logic [BUS_W-1:0]  bus_o
);
    localparam int unsigned Len  = NumElem * ELEM_W;
    localparam int unsigned CntW = (NumElem > 1) ? $clog2(NumElem) : 1;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic [31:0]      shamt;

    assign full_o = (cnt_q == CntW'(NumElem - 1));
    assign bus_o  = bus_q;
    assign shamt  = 32'(Len - ELEM_W) - 32'(cnt_q) * 32'(ELEM_W);

    always_comb begin
        cnt_d = cnt_q;
        bus_d = bus_q;
        if (clr_i) begin
            cnt_d = '0;
            bus_d = '0;
        end else if (wr_en_i) begin
            bus_d = (bus_q & ~(BUS_W'({ELEM_W{1'b1}}) << shamt)) | (BUS_W'(data_i) << shamt);
            // Wrap on the last slot so the counter is ready for the next matrix.
            cnt_d = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            bus_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            bus_q <= bus_d;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Streams matrices A and B into packed buses, checks in_last framing, hands off via valid/ack.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int unsigned aRow   = 3,
    parameter int unsigned aCol   = 2,
    parameter int unsigned bRow   = 2,
    parameter int unsigned bCol   = 3,
    parameter int unsigned ELEM_W = DEF_ELEM_W,
    parameter int unsigned BUS_W  = DEF_BUS_W
) (
    input logic            clk,
    input logic            rst,
    matrix_loader_if.slave bus
);
    localparam int unsigned matrixALen = matrix_len(aRow, aCol, ELEM_W);
    localparam int unsigned matrixBLen = matrix_len(bRow, bCol, ELEM_W);

    if (aCol != bRow || matrixALen > BUS_W || matrixBLen > BUS_W) begin : g_param_err
        $error("matrix_loader: aCol must equal bRow and both matrices must fit in BUS_W");
    end

    state_e state_q, state_d;
    logic   in_ready, xfer, clr, a_wr, b_wr, a_full, b_full;

    assign in_ready      = (state_q == StLoadA) || (state_q == StLoadB);
    assign xfer          = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.mat_valid = (state_q == StHold);
    assign bus.err       = (state_q == StErr);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        a_wr    = 1'b0;
        b_wr    = 1'b0;
        case (state_q)
            StIdle, StErr: begin
                if (bus.start) begin
                    state_d = StLoadA;
                    clr     = 1'b1;
                end
            end
            StLoadA: begin
                // A framing error consumes the element without writing it.
                if (xfer) begin
                    if (bus.in_last != a_full) begin
                        state_d = StErr;
                    end else begin
                        a_wr = 1'b1;
                        if (a_full) state_d = StLoadB;
                    end
                end
            end
            StLoadB: begin
                if (xfer) begin
                    if (bus.in_last != b_full) begin
                        state_d = StErr;
                    end else begin
                        b_wr = 1'b1;
                        if (b_full) state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.mat_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    elem_packer #(
        .NumElem (aRow * aCol),
        .ELEM_W  (ELEM_W),
        .BUS_W   (BUS_W)
    ) u_pack_a (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .wr_en_i (a_wr),
        .data_i  (bus.in_data),
        .full_o  (a_full),
        .bus_o   (bus.a_out)
    );

    elem_packer #(
        .NumElem (bRow * bCol),
        .ELEM_W  (ELEM_W),
        .BUS_W   (BUS_W)
    ) u_pack_b (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .wr_en_i (b_wr),
        .data_i  (bus.in_data),
        .full_o  (b_full),
        .bus_o   (bus.b_out)
    );

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Producer side of the matrix-multiply datapath. Accepts matrix elements one at a time over a valid/ready stream and packs matrices A and B, row-major, into the flat buses that the multiplier consumes. Presents them with a valid/ack handshake. Sits between the host/test stimulus and the multiplier's `a`/`b` inputs.

## Interface
Parameters:
- `aRow`, default 3: rows of A.
- `aCol`, default 2: columns of A; must equal `bRow`.
- `bRow`, default 2: rows of B.
- `bCol`, default 3: columns of B.
- `ELEM_W`, default 8: element width in bits.
- `BUS_W`, default 128: width of `a_out`/`b_out`.
- Derived: `matrixALen = aRow*aCol*ELEM_W` and `matrixBLen = bRow*bCol*ELEM_W`; both must be ≤ `BUS_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; begins a load. Honoured only in IDLE or ERR.
- `in_data` in ELEM_W: element value.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_last` in 1: marks the final element of A and the final element of B.
- `in_ready` out 1: loader accepts an element this cycle.
- `a_out` out BUS_W: packed A.
- `b_out` out BUS_W: packed B.
- `mat_valid` out 1: `a_out`/`b_out` complete and stable.
- `mat_ack` in 1: consumer has taken the matrices.
- `err` out 1: framing error; sticky.

## Operation
- States: IDLE, LOAD_A, LOAD_B, HOLD, ERR.
- IDLE→LOAD_A on `start`. On that edge, clear `a_out`, `b_out` and the element counter.
- Transfer = `in_valid && in_ready`. `in_ready` = 1 only in LOAD_A and LOAD_B.
- Element k (0-based, row-major) of A is written to `a_out[matrixALen-1-k*ELEM_W -: ELEM_W]`. The first element received lands at the MSB of the used field; bits ≥ `matrixALen` stay 0. B packs the same way into `b_out`.
- LOAD_A→LOAD_B on transfer of element `aRow*aCol-1`; the counter resets to 0.
- LOAD_B→HOLD on transfer of element `bRow*bCol-1`.
- `in_last` framing: it must be 1 on the final element of each matrix and 0 on all others. Any mismatch causes →ERR. The offending element is consumed and not written.
- HOLD: `mat_valid`=1 and buses frozen. On `mat_ack`, go →IDLE. Buses keep their values in IDLE until the next `start`.
- ERR: `err`=1, `in_ready`=0. Exits only via `start` (→LOAD_A, clears `err`) or reset.
- `start` in LOAD_A, LOAD_B or HOLD is ignored.
- `mat_ack` outside HOLD is ignored.
- Parameter check: elaboration-time error if `aCol != bRow` or either length exceeds `BUS_W`.

## Timing
- Reset (`rst`=0 at a rising edge) forces: state IDLE, `in_ready`=0, `mat_valid`=0, `err`=0, `a_out`=0, `b_out`=0, counter 0. Reset applies in any state, including mid-load, and discards the partial load.
- `in_ready` is a registered function of state. It is high from the cycle after `start`, and one transfer per cycle is possible.
- A transferred element is visible on the bus the cycle after the transfer edge.
- `mat_valid` rises the cycle after the final B transfer. Minimum load latency = `aRow*aCol + bRow*bCol` cycles after `start` with `in_valid` held high.
- `in_ready` falls in the same cycle that `mat_valid` rises. No element is accepted in HOLD.
- `mat_valid` falls the cycle after the `mat_ack` edge. `mat_ack` may already be high when `mat_valid` rises, giving a one-cycle HOLD.
- `start` and `mat_ack` in the same HOLD cycle: the ack is honoured and the start is ignored.
- `err` rises the cycle after the offending transfer.

## Structure
- Shared package `matrix_pkg`: `ELEM_W` default, the state enumeration (IDLE=0, LOAD_A=1, LOAD_B=2, HOLD=3, ERR=4, 3-bit) and the length-calculation constants shared with the multiplier.
- One sub-module, `elem_packer`, instanced twice (A and B). It contains an element counter, a packed register with a clear input, a write-enable, and a `full` flag on the last index. The top level holds the FSM and the `in_last` checks.

## Test plan
- Nominal 3×2 / 2×3 load: A = 1,2,1,2,1,2 and B = six 1s, streamed back-to-back, `in_last` on elements 6 and 12. Required: `a_out[47:0]`=48'h010201020102, `b_out[47:0]`=48'h010101010101, upper 80 bits 0, `mat_valid` high 12 cycles after `start`.
- Backpressure: `in_valid` toggled 1,0,1,0 with the same data. Required: identical buses, and `mat_valid` arrives after exactly 12 transfers.
- Framing error: `in_last` asserted on A element 4. Required: `err`=1 the next cycle and `in_ready`=0. A following `start` clears `err` and a clean reload gives the nominal result.
- Reset mid-load: `rst`=0 after 8 transfers. Required: all outputs 0 and IDLE. A fresh load then succeeds.
- Handshake edges: `mat_ack` held high before completion gives a one-cycle `mat_valid`. `start` pulsed during LOAD_B and during HOLD is ignored, and the counter is unaffected.
